bcd_updown_counter: RTL and testbench

Parametrised N-digit packed-BCD up/down counter with synchronous load, clear and count enable, plus a registered terminal-count pulse for cascading. It is the next generation of the team's 3-digit BCD incrementor: digit count is configurable, it counts in both directions, and it supports wrap or saturate at the range limits. It sits in BCD display and timekeeping datapaths, and a second instance can be chained through `tc`.

---
 rtl/bcd_updown_counter.sv | 88 ++++++++
 tb/tb_bcd_updown_counter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// N-digit packed-BCD up/down counter with clear/load/enable, wrap or saturate, and a terminal-count pulse.
// Optional invalid-load rejection with an err flag when BCD_INVALID_DETECT_EN is defined.
module bcd_updown_counter #(
  parameter int DIGITS = 3,
  parameter int WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  zero,
  output logic                  err
);

  localparam int W = 4 * DIGITS;

  logic [DIGITS:0]  chain;
  logic [DIGITS-1:0] dig_max;
  logic [DIGITS-1:0] dig_min;
  logic [W-1:0]     stepped;
  logic             at_limit;

  // chain[i] is the carry (up) or borrow (down) into digit i; digit 0 is fed by en.
  assign chain[0] = en;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] d;
    logic [3:0] inc_d;
    logic [3:0] dec_d;

    assign d          = count[4*i +: 4];
    assign inc_d      = (d >= 4'd9) ? 4'd0 : d + 4'd1;
    assign dec_d      = (d == 4'd0) ? 4'd9 : d - 4'd1;
    assign dig_max[i] = (d == 4'd9);
    assign dig_min[i] = (d == 4'd0);
    assign stepped[4*i +: 4] = !chain[i] ? d : (up ? inc_d : dec_d);
    assign chain[i+1] = chain[i] & (up ? (d >= 4'd9) : (d == 4'd0));
  end

  assign at_limit = en & (up ? (&dig_max) : (&dig_min));

`ifdef BCD_INVALID_DETECT_EN
  logic [DIGITS-1:0] nib_bad;
  logic              load_bad;

  for (genvar j = 0; j < DIGITS; j++) begin : g_chk
    assign nib_bad[j] = (load_val[4*j +: 4] > 4'd9);
  end
  assign load_bad = |nib_bad;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tc    <= 1'b0;
      err   <= 1'b0;
    end else begin
      tc  <= 1'b0;
      err <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (load) begin
`ifdef BCD_INVALID_DETECT_EN
        if (load_bad) err <= 1'b1;
        else          count <= load_val;
`else
        count <= load_val;
`endif
      end else if (en) begin
        if (at_limit) begin
          tc <= 1'b1;
          // Saturating build holds at the limit; wrapping build takes the rippled value.
          if (WRAP != 0) count <= stepped;
        end else begin
          count <= stepped;
        end
      end
    end
  end

  assign zero = (count == '0);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter: a wrapping and a saturating 3-digit instance share stimulus
// and are checked against a decimal-arithmetic reference model.
module tb_bcd_updown_counter;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        load;
  logic [11:0] load_val;
  logic        en;
  logic        up;

  logic [11:0] w_count, s_count;
  logic        w_tc, s_tc, w_zero, s_zero, w_err, s_err;

  logic [11:0] m_w, m_s;
  logic [29:0] exp_q[$];
  int          n_cmp;
  int          n_err;

  bcd_updown_counter #(.DIGITS(3), .WRAP(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .count(w_count), .tc(w_tc), .zero(w_zero), .err(w_err)
  );

  bcd_updown_counter #(.DIGITS(3), .WRAP(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .count(s_count), .tc(s_tc), .zero(s_zero), .err(s_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [11:0] int2bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'((v / 100) % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  // Reference model: returns {err, tc, count} after one edge.
  function automatic logic [13:0] model(input logic [11:0] c, input bit wrap, input logic cl,
                                        input logic ld, input logic [11:0] lv,
                                        input logic e, input logic u);
    int  v;
    bit  lv_ok;
    if (cl) return 14'd0;
    if (ld) begin
      lv_ok = (lv[11:8] <= 4'd9) && (lv[7:4] <= 4'd9) && (lv[3:0] <= 4'd9);
`ifdef BCD_INVALID_DETECT_EN
      if (!lv_ok) return {1'b1, 1'b0, c};
`endif
      return {2'b00, lv};
    end
    if (!e) return {2'b00, c};
    v = bcd2int(c);
    if (u) begin
      if (v == 999) return wrap ? {2'b01, 12'h000} : {2'b01, c};
      return {2'b00, int2bcd(v + 1)};
    end
    if (v == 0) return wrap ? {2'b01, 12'h999} : {2'b01, c};
    return {2'b00, int2bcd(v - 1)};
  endfunction

  task automatic check_out();
    logic [29:0] e;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("wrap_count", {20'd0, w_count}, {20'd0, e[29:18]});
    check("wrap_tc",    {31'd0, w_tc},    {31'd0, e[17]});
    check("wrap_zero",  {31'd0, w_zero},  {31'd0, e[16]});
    check("wrap_err",   {31'd0, w_err},   {31'd0, e[15]});
    check("sat_count",  {20'd0, s_count}, {20'd0, e[14:3]});
    check("sat_tc",     {31'd0, s_tc},    {31'd0, e[2]});
    check("sat_zero",   {31'd0, s_zero},  {31'd0, e[1]});
    check("sat_err",    {31'd0, s_err},   {31'd0, e[0]});
  endtask

  // driver: apply one cycle of inputs, predict, then compare after the edge
  task automatic drive(input logic c, input logic l, input logic [11:0] lv,
                       input logic e, input logic u);
    logic [13:0] rw, rs;
    clr = c; load = l; load_val = lv; en = e; up = u;
    rw = model(m_w, 1'b1, c, l, lv, e, u);
    rs = model(m_s, 1'b0, c, l, lv, e, u);
    m_w = rw[11:0];
    m_s = rs[11:0];
    exp_q.push_back({rw[11:0], rw[12], (rw[11:0] == 12'h000), rw[13],
                     rs[11:0], rs[12], (rs[11:0] == 12'h000), rs[13]});
    @(posedge clk);
    #1;
    check_out();
  endtask

  function automatic logic [11:0] rand_bcd();
    logic [11:0] r;
    r[11:8] = 4'($urandom_range(0, 9));
    r[7:4]  = 4'($urandom_range(0, 9));
    r[3:0]  = 4'($urandom_range(0, 9));
    return r;
  endfunction

  initial begin
    logic [11:0] lv;
    n_cmp = 0; n_err = 0;
    m_w = '0; m_s = '0;
    clr = 0; load = 0; load_val = '0; en = 0; up = 1;
    rst_n = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_count", {20'd0, w_count}, 32'd0);
    check("rst_tc",    {31'd0, w_tc},    32'd0);
    check("rst_err",   {31'd0, w_err},   32'd0);
    check("rst_zero",  {31'd0, w_zero},  32'd1);
    check("rst_scount", {20'd0, s_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // BCD carry across digits
    drive(0, 1, 12'h099, 0, 1);
    drive(0, 0, 12'h000, 1, 1);
    drive(0, 0, 12'h000, 1, 1);
    // top limit, then back down
    drive(0, 1, 12'h999, 0, 1);
    drive(0, 0, 12'h000, 1, 1);
    drive(0, 0, 12'h000, 1, 0);
    // bottom limit, three steps down
    drive(0, 1, 12'h000, 0, 0);
    repeat (3) drive(0, 0, 12'h000, 1, 0);
    // approach top from 998
    drive(0, 1, 12'h998, 0, 1);
    repeat (3) drive(0, 0, 12'h000, 1, 1);
    // priority clr > load > en
    drive(1, 1, 12'h123, 1, 1);
    drive(0, 1, 12'h123, 1, 1);
    // invalid-nibble load, then a valid one
    drive(0, 1, 12'h1A3, 0, 1);
    drive(0, 1, 12'h456, 0, 1);
    // hold with nothing asserted
    drive(0, 0, 12'h789, 0, 0);

    // random traffic with valid values, biased toward the limits
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) lv = $urandom_range(0, 1) ? 12'h999 : 12'h000;
      else                           lv = rand_bcd();
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 2), lv,
            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    // asynchronous reset in the middle of a counting cycle
    drive(0, 1, 12'h456, 0, 1);
    drive(0, 0, 12'h000, 1, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_wcount", {20'd0, w_count}, 32'd0);
    check("async_scount", {20'd0, s_count}, 32'd0);
    check("async_zero",   {31'd0, w_zero},  32'd1);
    m_w = '0; m_s = '0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 12'h000, 1, 1);
    drive(0, 0, 12'h000, 1, 1);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
